// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-stage constants and types for the sequential shift unit.
package rv32i_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned REG_W   = 5;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SR     = 3'b101;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } sh_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One shift step of up to 7 bit positions; SRA replicates the operand's bit 31.
  function automatic logic [XLEN-1:0] shift_op(input logic [XLEN-1:0] op,
                                               input sh_type_t        kind,
                                               input logic [2:0]      amt);
    logic [XLEN-1:0] r;
    case (kind)
      SH_SLL:  r = op << amt;
      SH_SRL:  r = op >> amt;
      default: r = XLEN'($signed(op) >>> amt);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_shift_dec.sv
// Combinational decode of the D/E instruction into shift-enable, shift type and amount.
module ex_shift_dec
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0]    ir,
  input  logic [XLEN-1:0]    rs2,
  input  logic [XLEN-1:0]    imm,
  output logic               is_shift,
  output sh_type_t           sh_type,
  output logic [SHAMT_W-1:0] shamt
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_op;
  logic       is_opimm;

  assign opc      = ir[6:0];
  assign f3       = ir[14:12];
  assign is_op    = (opc == OPC_OP);
  assign is_opimm = (opc == OPC_OPIMM);

  assign is_shift = (is_op || is_opimm) && ((f3 == F3_SLL) || (f3 == F3_SR));
  assign sh_type  = (f3 == F3_SLL) ? SH_SLL : (ir[30] ? SH_SRA : SH_SRL);
  assign shamt    = is_op ? rs2[SHAMT_W-1:0] : imm[SHAMT_W-1:0];

  // Fields that play no part in shift decode.
  logic unused_ok;
  assign unused_ok = ^{ir[31], ir[29:15], ir[11:7], rs2[XLEN-1:SHAMT_W], imm[XLEN-1:SHAMT_W]};

endmodule

// File: rtl/ex_seq_shifter.sv
// Iterative RV32I shift unit reading the D/E register; stalls upstream while shifting.
// Define SHIFT_STEP4_EN to take 4-bit steps while at least 4 positions remain.
module ex_seq_shifter
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [XLEN-1:0]   PC_E,
  input  logic [XLEN-1:0]   IR_E,
  input  logic [XLEN-1:0]   rs1_E,
  input  logic [XLEN-1:0]   rs2_E,
  input  logic [XLEN-1:0]   Imm_E,
  output logic              stall,
  output logic              out_valid,
  output logic [XLEN-1:0]   res,
  output logic [REG_W-1:0]  rd,
  output logic [XLEN-1:0]   pc_out
);

  state_t               state, state_n;
  logic [XLEN-1:0]      op_q, op_n;
  logic [SHAMT_W-1:0]   cnt_q, cnt_n;
  sh_type_t             typ_q, typ_n;
  logic                 accept_c;

  logic                 dec_is_shift;
  sh_type_t             dec_type;
  logic [SHAMT_W-1:0]   dec_shamt;

  ex_shift_dec u_dec (
    .ir       (IR_E),
    .rs2      (rs2_E),
    .imm      (Imm_E),
    .is_shift (dec_is_shift),
    .sh_type  (dec_type),
    .shamt    (dec_shamt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      typ_q     <= SH_SLL;
      out_valid <= 1'b0;
      res       <= '0;
      rd        <= '0;
      pc_out    <= '0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      cnt_q     <= cnt_n;
      typ_q     <= typ_n;
      out_valid <= (state_n == DONE);
      if (state_n == DONE) begin
        res <= op_n;
      end
      if (accept_c) begin
        rd     <= IR_E[11:7];
        pc_out <= PC_E;
      end
    end
  end

  // Next-state, datapath step and stall; flush and reset override everything else.
  always_comb begin
    state_n  = state;
    op_n     = op_q;
    cnt_n    = cnt_q;
    typ_n    = typ_q;
    accept_c = 1'b0;
    stall    = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid && dec_is_shift && !flush) begin
          accept_c = 1'b1;
          stall    = 1'b1;
          op_n     = rs1_E;
          cnt_n    = dec_shamt;
          typ_n    = dec_type;
          state_n  = (dec_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        stall = 1'b1;
`ifdef SHIFT_STEP4_EN
        if (cnt_q >= SHAMT_W'(4)) begin
          op_n  = shift_op(op_q, typ_q, 3'd4);
          cnt_n = cnt_q - SHAMT_W'(4);
        end else begin
          op_n  = shift_op(op_q, typ_q, 3'd1);
          cnt_n = cnt_q - SHAMT_W'(1);
        end
`else
        op_n  = shift_op(op_q, typ_q, 3'd1);
        cnt_n = cnt_q - SHAMT_W'(1);
`endif
        state_n = (cnt_n == '0) ? DONE : SHIFT;
      end
      DONE: begin
        // Never accept here: the D/E register still holds the finished instruction.
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (flush) begin
      state_n  = IDLE;
      stall    = 1'b0;
      accept_c = 1'b0;
    end
    if (!rst) begin
      stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_seq_shifter.sv
// Self-checking bench for ex_seq_shifter: directed cases plus random shifts against an arithmetic model.
module tb_ex_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic [31:0] PC_E, IR_E, rs1_E, rs2_E, Imm_E;
  logic        stall;
  logic        out_valid;
  logic [31:0] res;
  logic [4:0]  rd;
  logic [31:0] pc_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  ex_seq_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .flush     (flush),
    .PC_E      (PC_E),
    .IR_E      (IR_E),
    .rs1_E     (rs1_E),
    .rs2_E     (rs2_E),
    .Imm_E     (Imm_E),
    .stall     (stall),
    .out_valid (out_valid),
    .res       (res),
    .rd        (rd),
    .pc_out    (pc_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // kind: 0=SLL 1=SRL 2=SRA; shifts expressed as multiply/divide by 2**amt.
  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int amt, input int kind);
    logic [63:0] pw;
    logic [63:0] prod;
    pw = 64'd1;
    for (int i = 0; i < amt; i++) pw = pw * 64'd2;
    case (kind)
      0: begin
        prod = 64'(v) * pw;
        return prod[31:0];
      end
      1: return v / pw[31:0];
      default: return v[31] ? ~((~v) / pw[31:0]) : v / pw[31:0];
    endcase
  endfunction

  function automatic int ref_occ(input int s);
`ifdef SHIFT_STEP4_EN
    return s / 4 + s % 4 + 2;
`else
    return s + 2;
`endif
  endfunction

  function automatic logic [31:0] mk_ir(input int kind, input bit is_imm, input logic [4:0] rdn);
    logic [31:0] junk;
    logic [6:0]  opc;
    logic [2:0]  f3;
    junk = $urandom;
    opc  = is_imm ? 7'b0010011 : 7'b0110011;
    f3   = (kind == 0) ? 3'b001 : 3'b101;
    return {junk[0], (kind == 2), junk[14:0], f3, rdn, opc};
  endfunction

  // Presents one instruction, holds it while stalled and checks timing and results.
  task automatic do_shift(input string tag, input logic [31:0] ir, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                          input logic [31:0] exp_res, input int exp_occ);
    int k;
    int stall_cnt;
    bit done;
    @(negedge clk);
    in_valid = 1'b1;
    IR_E = ir; rs1_E = a; rs2_E = b; Imm_E = imm; PC_E = pc;
    #1;
    check({tag, ".res_hold"}, res, last_res);
    check({tag, ".ov_idle"}, 32'(out_valid), 32'd0);
    stall_cnt = stall ? 1 : 0;
    k = 0;
    done = 1'b0;
    while (!done && k < 100) begin
      @(negedge clk);
      #1;
      k++;
      if (out_valid) done = 1'b1;
      else if (stall) stall_cnt++;
    end
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".occupancy"}, 32'(k + 1), 32'(exp_occ));
    check({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(exp_occ - 1));
    check({tag, ".stall_done"}, 32'(stall), 32'd0);
    check({tag, ".res"}, res, exp_res);
    check({tag, ".rd"}, 32'(rd), 32'(ir[11:7]));
    check({tag, ".pc_out"}, pc_out, pc);
    in_valid = 1'b0;
    last_res = exp_res;
  endtask

  initial begin
    int kind;
    bit is_imm;
    int amt;
    logic [31:0] a, b, imm, ir, pc;
    bit ov_seen;

    rst = 1'b0; flush = 1'b0; PC_E = '0; rs1_E = '0; rs2_E = '0; Imm_E = 32'd5;
    in_valid = 1'b1;
    IR_E = mk_ir(0, 1'b1, 5'd1);
    last_res = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset.stall", 32'(stall), 32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.res", res, 32'd0);
    check("reset.rd", 32'(rd), 32'd0);
    check("reset.pc_out", pc_out, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;

    do_shift("slli31", mk_ir(0, 1'b1, 5'd3), 32'h1, 32'h0, 32'd31, 32'h100,
             32'h80000000, ref_occ(31));
    do_shift("sra4", mk_ir(2, 1'b0, 5'd7), 32'h80000000, 32'd4, 32'h0, 32'h104,
             32'hF8000000, ref_occ(4));
    do_shift("srl0", mk_ir(1, 1'b0, 5'd9), 32'h12345678, 32'h20, 32'h0, 32'h108,
             32'h12345678, 2);

    // Non-shift instruction is ignored.
    @(negedge clk);
    in_valid = 1'b1; IR_E = 32'h002081B3; rs1_E = 32'h5; rs2_E = 32'h3;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("add.stall", 32'(stall), 32'd0);
      check("add.out_valid", 32'(out_valid), 32'd0);
      check("add.res", res, last_res);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // Flush on the third SHIFT cycle of an SLL by 10.
    @(negedge clk);
    in_valid = 1'b1; IR_E = mk_ir(0, 1'b0, 5'd12); rs1_E = 32'hA5A5_0F0F; rs2_E = 32'd10;
    PC_E = 32'h200;
    #1;
    check("flush.stall_acc", 32'(stall), 32'd1);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush.stall_drop", 32'(stall), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush.out_valid", 32'(out_valid), 32'd0);
    ov_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      #1;
      ov_seen |= out_valid;
    end
    check("flush.no_result", 32'(ov_seen), 32'd0);
    check("flush.res", res, last_res);
    do_shift("post_flush", mk_ir(1, 1'b1, 5'd13), 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h204,
             32'hDEAD_BEEF, 2);

    // Random shifts, back to back.
    for (int n = 0; n < 30; n++) begin
      kind   = $urandom_range(0, 2);
      is_imm = 1'($urandom_range(0, 1));
      a      = $urandom;
      b      = $urandom;
      imm    = $urandom;
      pc     = $urandom & 32'hFFFF_FFFC;
      amt    = is_imm ? int'(imm[4:0]) : int'(b[4:0]);
      ir     = mk_ir(kind, is_imm, 5'($urandom_range(0, 31)));
      do_shift("rand", ir, a, b, imm, pc, ref_shift(a, amt, kind), ref_occ(amt));
    end

    // Asynchronous reset in the middle of a long shift.
    @(negedge clk);
    in_valid = 1'b1; IR_E = mk_ir(0, 1'b0, 5'd20); rs1_E = 32'hFFFF_FFFF; rs2_E = 32'd20;
    PC_E = 32'h300;
    repeat (5) @(negedge clk);
    #1;
    check("midrst.stall_pre", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst.stall", 32'(stall), 32'd0);
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.res", res, 32'd0);
    check("midrst.rd", 32'(rd), 32'd0);
    check("midrst.pc_out", pc_out, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_res = '0;
    do_shift("srli_after_rst", mk_ir(1, 1'b1, 5'd4), 32'hF0000000, 32'h0, 32'd4, 32'h304,
             32'h0F000000, ref_occ(4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_seq_shifter.md
# ex_seq_shifter

Iterative shift unit for the RV32I execute stage, acting as the reader of the decode-to-execute pipeline register. It consumes the D/E register outputs, detects SLL/SRL/SRA/SLLI/SRLI/SRAI, and computes the result over several cycles. While it works, it asserts a stall so the D/E register and the upstream stages hold their contents. Results go to the execute-to-memory register with a one-cycle valid strobe.

## Interface
Parameters:
- none. The datapath is fixed at 32 bits for RV32I.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  the D/E register holds a live instruction.
- flush  input  1  synchronous kill from branch resolution.
- PC_E  input  32  instruction PC from the D/E register.
- IR_E  input  32  instruction word from the D/E register.
- rs1_E  input  32  first source operand.
- rs2_E  input  32  second source operand.
- Imm_E  input  32  decoded immediate.
- stall  output  1  holds the D/E register and upstream stages.
- out_valid  output  1  one-cycle strobe marking a valid result.
- res  output  32  shift result.
- rd  output  5  destination register, taken from IR_E[11:7].
- pc_out  output  32  PC of the completed instruction.

## Operation
- Shift decode:
  - opcode 0110011 (OP) or 0010011 (OP-IMM);
  - funct3 001 selects SLL;
  - funct3 101 selects SRL when IR_E[30]=0 and SRA when IR_E[30]=1.
  - Any other instruction is ignored: stall=0 and no state change.
- Shift amount:
  - OP uses rs2_E[4:0];
  - OP-IMM uses Imm_E[4:0];
  - upper bits are ignored.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - When in_valid is high and the instruction decodes as a shift: latch the operand from rs1_E, the count, the type, rd and PC_E.
  - Next state is SHIFT if count≠0, otherwise DONE.
- SHIFT:
  - Each cycle, shift by 1 and decrement count.
  - Enter DONE when count reaches 0.
  - SLL and SRL fill with 0. SRA fills with the latched bit 31.
- DONE:
  - out_valid=1 and res is valid. Next state is IDLE.
  - The unit never accepts a new instruction in DONE, so it cannot retrigger on the same D/E contents.
- stall (combinational):
  - high when in IDLE with in_valid and a shift decoded;
  - high in SHIFT;
  - low in DONE, so the D/E register advances on the DONE edge.
- flush:
  - In any state it forces IDLE on the next edge and suppresses out_valid for that instruction.
  - While flush is high, stall=0.
  - If flush coincides with DONE, out_valid is still driven in that cycle. Downstream qualifies it with flush.
- Reset (rst=0, asynchronous, including mid-shift):
  - state IDLE;
  - res, rd, pc_out, count and the operand register all 0;
  - out_valid=0;
  - stall forced 0 while reset is asserted.

## Timing
- Latency, measured from the accept edge to the out_valid cycle: shamt+1 cycles. The instruction occupies the unit for shamt+2 cycles in total.
- shamt=0: IDLE→DONE, so out_valid appears on the cycle after accept. Total occupancy 2 cycles.
- Back-to-back shifts: the second is accepted the cycle after DONE, with one IDLE cycle between results.
- res, rd and pc_out hold their values after DONE until the next accept.

## Configuration
- SHIFT_STEP4_EN defined:
  - the SHIFT state shifts by 4 and subtracts 4 whenever count≥4, and otherwise shifts by 1;
  - occupancy is floor(s/4)+(s mod 4)+2 cycles.
- Not defined: a single-bit step only, with occupancy s+2.
- Results are identical in both builds.

## Structure
- Shared package rv32i_pkg holds:
  - the opcode constants OPC_OP=7'b0110011 and OPC_OPIMM=7'b0010011;
  - the funct3 constants F3_SLL=3'b001 and F3_SR=3'b101;
  - the shift-type enum (SH_SLL, SH_SRL, SH_SRA);
  - the FSM state enum.
- One sub-module, ex_shift_dec: combinational decode of IR_E, rs2_E and Imm_E into is_shift, shift type and amount.

## Test plan
- SLLI with rs1_E=0x00000001 and Imm_E=31: res=0x80000000, stall high for 32 cycles, occupancy 33 cycles. With SHIFT_STEP4_EN, occupancy is 12.
- SRA with rs1_E=0x80000000 and rs2_E=4: res=0xF8000000 with occupancy 6. With SHIFT_STEP4_EN, occupancy is 3.
- SRL with rs2_E=0x00000020 (amount 0) and rs1_E=0x12345678: res=0x12345678, out_valid on the cycle after accept.
- ADD (IR_E=0x002081B3) with in_valid=1: stall stays 0, out_valid stays 0, res unchanged.
- SLL with shamt 10, flush asserted on the third SHIFT cycle: IDLE on the next edge, no out_valid, stall drops immediately.
- rst pulled low mid-SHIFT: stall, out_valid and res are 0 at once. After release, a fresh SRLI 0xF0000000 >> 4 yields 0x0F000000.
